// File: rtl/sync_filter_pkg.sv
// Shared helpers for the synchronizer/glitch-filter block.
package sync_filter_pkg;

  // Counter width able to hold 0..fc.
  function automatic int cnt_width(input int fc);
    return $clog2(fc + 1);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: multi-flop synchronizer followed by a consecutive-cycle
// level filter with registered rise/fall pulses.
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int   SYNC_STAGES   = 3,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_i};
    s       = sync_q[SYNC_STAGES-1];
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any cycle where s agrees with the output level discards a partial run.
    if (s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      cnt_q   <= '0;
      level_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sync_filter.sv
// WIDTH independent synchronize-and-debounce channels with edge pulses.
module sync_filter #(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 3,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sig,
  output logic [WIDTH-1:0] out_sig,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_BIT    (RESET_VALUE[i])
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in_i   (in_sig[i]),
      .level_o(out_sig[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: two configurations driven from the same inputs,
// per-cycle scoreboard plus directed scenario checks.
module tb_sync_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_sig = 4'h0;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];

  // Model state: pipe holds 4-bit sync stages, hist holds 4 recent s bits per channel.
  logic [15:0] m_pipe_a = '0, m_hist_a = '0, m_pipe_b = '0, m_hist_b = '0;
  logic [3:0]  m_out_a = '0, m_rise_a, m_fall_a, m_out_b = '0, m_rise_b, m_fall_b;

  int rise_cnt, rise_at, seen_cnt;
  logic [3:0] seen_val;
  logic       rise_seen;
  logic [3:0] rnd_v;
  logic       rnd_r;

  always #5 clk = ~clk;

  sync_filter #(
    .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(4'h0)
  ) dut_a (
    .clk(clk), .rst(rst), .in_sig(in_sig), .out_sig(out_a), .rise(rise_a), .fall(fall_a)
  );

  sync_filter #(
    .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(4'hA)
  ) dut_b (
    .clk(clk), .rst(rst), .in_sig(in_sig), .out_sig(out_b), .rise(rise_b), .fall(fall_b)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output level flips once the last fc synchronized samples all disagree with it.
  task automatic mdl_step(input int ss, input int fc, input logic [3:0] rv,
                          input logic rst_v, input logic [3:0] in_v,
                          inout logic [15:0] pipe, inout logic [15:0] hist,
                          inout logic [3:0] out, output logic [3:0] rs, output logic [3:0] fl);
    logic [3:0] s_old, mask, h, want;
    rs = '0;
    fl = '0;
    if (rst_v) begin
      pipe = {4{rv}};
      out  = rv;
      for (int ch = 0; ch < 4; ch++) hist[ch*4 +: 4] = {4{rv[ch]}};
    end else begin
      s_old = pipe[(ss-1)*4 +: 4];
      mask  = 4'((1 << fc) - 1);
      for (int ch = 0; ch < 4; ch++) begin
        h = {hist[ch*4 +: 3], s_old[ch]};
        hist[ch*4 +: 4] = h;
        want = {4{~out[ch]}};
        if ((h & mask) == (want & mask)) begin
          if (!out[ch]) rs[ch] = 1'b1;
          else          fl[ch] = 1'b1;
          out[ch] = ~out[ch];
        end
      end
      pipe = {pipe[11:0], in_v};
    end
  endtask

  task automatic step(input logic [3:0] in_v, input logic rst_v);
    @(negedge clk);
    in_sig = in_v;
    rst    = rst_v;
    @(posedge clk);
    mdl_step(3, 4, 4'h0, rst_v, in_v, m_pipe_a, m_hist_a, m_out_a, m_rise_a, m_fall_a);
    mdl_step(2, 1, 4'hA, rst_v, in_v, m_pipe_b, m_hist_b, m_out_b, m_rise_b, m_fall_b);
    exp_a_q.push_back({m_out_a, m_rise_a, m_fall_a});
    exp_b_q.push_back({m_out_b, m_rise_b, m_fall_b});
    #1;
    check("sb_a", {out_a, rise_a, fall_a}, exp_a_q.pop_front());
    check("sb_b", {out_b, rise_b, fall_b}, exp_b_q.pop_front());
    check("a_rise_fall_excl", {8'h0, rise_a & fall_a}, 12'h0);
  endtask

  initial begin
    // Reset with all inputs high, then release.
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check("rst_out_a", {8'h0, out_a}, 12'h0);
    check("rst_pulse_a", {4'h0, rise_a, fall_a}, 12'h0);
    check("rst_out_b", {8'h0, out_b}, 12'hA);
    for (int k = 1; k <= 7; k++) begin
      step(4'hF, 1'b0);
      if (k < 7) check("rel_wait", {8'h0, out_a}, 12'h0);
    end
    check("rel_out", {8'h0, out_a}, 12'hF);
    check("rel_rise", {8'h0, rise_a}, 12'hF);
    step(4'hF, 1'b0);
    check("rel_rise_once", {8'h0, rise_a}, 12'h0);

    // Glitch: 3-cycle high on channel 0 is suppressed.
    for (int k = 0; k < 10; k++) step(4'h0, 1'b0);
    rise_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin step(4'h1, 1'b0); rise_seen |= rise_a[0]; end
    for (int k = 0; k < 10; k++) begin step(4'h0, 1'b0); rise_seen |= rise_a[0]; end
    check("glitch_rise", {11'h0, rise_seen}, 12'h0);
    check("glitch_out", {11'h0, out_a[0]}, 12'h0);

    // 4-cycle high run is accepted, then the low run produces a fall.
    for (int k = 1; k <= 11; k++) begin
      step((k <= 4) ? 4'h1 : 4'h0, 1'b0);
      if (k == 6)  check("run4_pre", {11'h0, out_a[0]}, 12'h0);
      if (k == 7)  check("run4_rise", {10'h0, out_a[0], rise_a[0]}, 12'h3);
      if (k == 10) check("run4_hold", {11'h0, out_a[0]}, 12'h1);
      if (k == 11) check("run4_fall", {10'h0, out_a[0], fall_a[0]}, 12'h1);
    end

    // Chatter on channel 2: 1,1,1,0,1,1,1,1 then held high.
    for (int k = 0; k < 6; k++) step(4'h0, 1'b0);
    rise_cnt = 0;
    rise_at  = -1;
    for (int k = 1; k <= 16; k++) begin
      step((k == 4) ? 4'h0 : 4'h4, 1'b0);
      if (rise_a[2]) begin rise_cnt++; rise_at = k; end
    end
    check("chatter_cnt", 12'(rise_cnt), 12'd1);
    check("chatter_at", 12'(rise_at), 12'd11);

    // Simultaneous rise on channels 0 and 2.
    for (int k = 0; k < 10; k++) step(4'h0, 1'b0);
    seen_cnt = 0;
    seen_val = '0;
    for (int k = 0; k < 10; k++) begin
      step(4'h5, 1'b0);
      if (rise_a != 4'h0) begin seen_cnt++; seen_val = rise_a; end
    end
    check("simul_cnt", 12'(seen_cnt), 12'd1);
    check("simul_val", {8'h0, seen_val}, 12'h5);
    check("simul_out", {8'h0, out_a}, 12'h5);

    // Reset arriving with the count at 3 discards it.
    for (int k = 0; k < 10; k++) step(4'h0, 1'b0);
    for (int k = 0; k < 6; k++) step(4'hF, 1'b0);
    step(4'hF, 1'b1);
    check("midrst_out", {8'h0, out_a}, 12'h0);
    check("midrst_pulse", {4'h0, rise_a, fall_a}, 12'h0);
    for (int k = 1; k <= 7; k++) begin
      step(4'hF, 1'b0);
      if (k == 6) check("midrst_wait", {8'h0, out_a}, 12'h0);
    end
    check("midrst_out2", {4'h0, out_a, rise_a}, 12'hFF);

    // Pure-sync configuration: single-cycle pulse with 3-edge latency.
    for (int k = 0; k < 5; k++) step(4'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step((k == 1) ? 4'h1 : 4'h0, 1'b0);
      if (k == 2) check("b_pulse_pre", {11'h0, out_b[0]}, 12'h0);
      if (k == 3) check("b_pulse_hi", {10'h0, out_b[0], rise_b[0]}, 12'h3);
      if (k == 4) check("b_pulse_lo", {10'h0, out_b[0], fall_b[0]}, 12'h1);
    end

    // Random runs with occasional reset.
    for (int n = 0; n < 120; n++) begin
      rnd_v = 4'($urandom_range(0, 15));
      rnd_r = ($urandom_range(0, 30) == 0);
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) step(rnd_v, rnd_r);
    end
    for (int k = 0; k < 10; k++) step(4'h3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
